vector_lsu: RTL

- Parametrised multi-beat vector load/store unit that replaces the single-cycle full-vector memory access of the current memory stage.
- Moves an N-lane x RW-bit vector through a narrower memory port, LPB lanes per beat, in unit-stride or strided mode.
- Sits between the EX/MEM pipeline register and data memory. It holds the pipeline through the request/ready handshake and returns a full vector plus its destination register for writeback.

---
 rtl/vlsu_pkg.sv | 22 ++
 rtl/vlsu_addr_gen.sv | 70 +++++++
 rtl/vector_lsu.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/vlsu_pkg.sv
// Shared types and helpers for the multi-beat vector load/store unit.
package vlsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vlsu_state_t;

  localparam logic UNIT    = 1'b0;
  localparam logic STRIDED = 1'b1;

  function automatic int beats(input int n, input int lpb, input logic strided);
    if (strided == STRIDED) begin
      beats = n;
    end else begin
      beats = (n + lpb - 1) / lpb;
    end
  endfunction

endpackage

// File: rtl/vlsu_addr_gen.sv
// Beat counter and per-beat address / lane-enable generator for vector_lsu.
module vlsu_addr_gen
  import vlsu_pkg::*;
#(
  parameter int N   = 6,
  parameter int LPB = 2,
  parameter int AW  = 24,
  parameter int SW  = 8,
  parameter int BW  = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [AW-1:0]  base,
  input  logic [SW-1:0]  stride,
  input  logic           mode,
  input  logic           load,
  input  logic           advance,
  output logic [AW-1:0]  mem_addr,
  output logic [LPB-1:0] mem_lane_en,
  output logic [BW-1:0]  beat_idx,
  output logic           last_beat
);

  logic [AW-1:0] addr_q, addr_d;
  logic [BW-1:0] beat_q, beat_d;

  // next address / beat: load restarts at base, advance steps by stride or LPB (wraps mod 2^AW)
  always_comb begin
    addr_d = addr_q;
    beat_d = beat_q;
    if (load) begin
      addr_d = base;
      beat_d = '0;
    end else if (advance) begin
      addr_d = addr_q + ((mode == STRIDED) ? AW'(stride) : AW'(LPB));
      beat_d = beat_q + BW'(1);
    end else begin
      addr_d = addr_q;
      beat_d = beat_q;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      beat_q <= '0;
    end else begin
      addr_q <= addr_d;
      beat_q <= beat_d;
    end
  end

  // strided beats use lane 0 only; the last unit-stride beat masks lanes past N
  always_comb begin
    mem_lane_en = '0;
    for (int j = 0; j < LPB; j++) begin
      if (mode == STRIDED) begin
        mem_lane_en[j] = (j == 0);
      end else begin
        mem_lane_en[j] = ((int'(beat_q) * LPB + j) < N);
      end
    end
  end

  assign mem_addr  = addr_q;
  assign beat_idx  = beat_q;
  assign last_beat = (int'(beat_q) == (beats(N, LPB, mode) - 1));

endmodule

// File: rtl/vector_lsu.sv
// Multi-beat vector load/store unit: streams an N-lane vector through an
// LPB-lane memory port in unit-stride or strided mode and returns it for writeback.
module vector_lsu
  import vlsu_pkg::*;
#(
  parameter int RW  = 24,
  parameter int N   = 6,
  parameter int LPB = 2,
  parameter int AW  = 24,
  parameter int SW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic              req_strided,
  input  logic [AW-1:0]     req_base,
  input  logic [SW-1:0]     req_stride,
  input  logic [3:0]        req_rc,
  input  logic [RW*N-1:0]   req_wdata,
  input  logic              flush,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [LPB-1:0]    mem_lane_en,
  output logic [RW*LPB-1:0] mem_wdata,
  input  logic [RW*LPB-1:0] mem_rdata,
  output logic              resp_valid,
  output logic              resp_store,
  output logic [3:0]        resp_rc,
  output logic [RW*N-1:0]   resp_rdata,
  output logic              stall
);

  localparam int BW = $clog2(N + 1);

  vlsu_state_t     state_q, state_d;
  logic            store_q, store_d, strided_q, strided_d, rd_pend_q, rd_pend_d;
  logic [SW-1:0]   stride_q, stride_d;
  logic [3:0]      rc_q, rc_d;
  logic [RW*N-1:0] wdata_q, wdata_d, acc_q, acc_d, resp_rdata_q, resp_rdata_d;
  logic [BW-1:0]   rd_beat_q, rd_beat_d;
  logic [LPB-1:0]  rd_en_q, rd_en_d;

  logic            issue, accept, gen_load, last_beat;
  logic [AW-1:0]   gen_addr;
  logic [LPB-1:0]  gen_en;
  logic [BW-1:0]   beat_idx;
  int              lane, wlane;

  assign issue      = (state_q == ISSUE);
  assign accept     = issue && mem_ready;
  assign req_ready  = (state_q == IDLE) && !flush;
  assign gen_load   = req_valid && req_ready;
  assign stall      = req_valid && !req_ready;
  assign mem_req    = issue;
  assign mem_we     = issue && store_q;
  assign mem_addr   = issue ? gen_addr : '0;
  assign mem_lane_en = issue ? gen_en : '0;
  assign resp_valid = (state_q == DONE) && !flush;
  assign resp_store = store_q;
  assign resp_rc    = rc_q;
  assign resp_rdata = resp_rdata_q;

  vlsu_addr_gen #(.N(N), .LPB(LPB), .AW(AW), .SW(SW), .BW(BW)) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .base       (req_base),
    .stride     (stride_q),
    .mode       (strided_q),
    .load       (gen_load),
    .advance    (accept),
    .mem_addr   (gen_addr),
    .mem_lane_en(gen_en),
    .beat_idx   (beat_idx),
    .last_beat  (last_beat)
  );

  // pack the current beat's store lanes onto the memory port
  always_comb begin
    mem_wdata = '0;
    wlane     = 0;
    for (int j = 0; j < LPB; j++) begin
      wlane = strided_q ? int'(beat_idx) : int'(beat_idx) * LPB + j;
      if (issue && store_q && gen_en[j]) begin
        mem_wdata[j*RW +: RW] = wdata_q[wlane*RW +: RW];
      end else begin
        mem_wdata[j*RW +: RW] = '0;
      end
    end
  end

  // FSM next state, request capture and load-data assembly
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    strided_d    = strided_q;
    stride_d     = stride_q;
    rc_d         = rc_q;
    wdata_d      = wdata_q;
    acc_d        = acc_q;
    resp_rdata_d = resp_rdata_q;
    rd_pend_d    = accept && !store_q && !flush;
    rd_beat_d    = beat_idx;
    rd_en_d      = gen_en;
    lane         = 0;

    // read data for the beat accepted last cycle; a flush drops it
    if (rd_pend_q && !flush) begin
      for (int j = 0; j < LPB; j++) begin
        lane = strided_q ? int'(rd_beat_q) : int'(rd_beat_q) * LPB + j;
        if (rd_en_q[j]) begin
          acc_d[lane*RW +: RW] = mem_rdata[j*RW +: RW];
        end else begin
          acc_d[lane*RW +: RW] = acc_d[lane*RW +: RW];
        end
      end
    end else begin
      acc_d = acc_q;
    end

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (gen_load) begin
            store_d   = req_store;
            strided_d = req_strided;
            stride_d  = req_stride;
            rc_d      = req_rc;
            wdata_d   = req_wdata;
            acc_d     = '0;
            state_d   = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
        ISSUE: begin
          if (accept && last_beat) begin
            state_d = store_q ? DONE : DRAIN;
          end else begin
            state_d = ISSUE;
          end
        end
        DRAIN:   state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (state_d == DONE) begin
      resp_rdata_d = store_q ? '0 : acc_d;
    end else begin
      resp_rdata_d = resp_rdata_q;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      strided_q    <= UNIT;
      stride_q     <= '0;
      rc_q         <= '0;
      wdata_q      <= '0;
      acc_q        <= '0;
      resp_rdata_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_beat_q    <= '0;
      rd_en_q      <= '0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      strided_q    <= strided_d;
      stride_q     <= stride_d;
      rc_q         <= rc_d;
      wdata_q      <= wdata_d;
      acc_q        <= acc_d;
      resp_rdata_q <= resp_rdata_d;
      rd_pend_q    <= rd_pend_d;
      rd_beat_q    <= rd_beat_d;
      rd_en_q      <= rd_en_d;
    end
  end

endmodule
